// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: AES SubBytes / InvSubBytes over one block, LANES bytes per cycle.
// Build option SBOX_FWD_EN adds the forward S-box; without it every block uses the inverse S-box.
module sub_bytes_engine #(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_block,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_block,
  output logic                     busy
);
  localparam int N     = BLOCK_BYTES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (LANES < 1 || (BLOCK_BYTES % LANES) != 0) begin : g_cfg_check
      $error("sub_bytes_engine: BLOCK_BYTES must be a positive multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [8*BLOCK_BYTES-1:0] data_q, data_d;
  logic                     rdy_en_q, rdy_en_d;
  logic                     accept;

  // S-boxes are GF(2^8) inversion plus the affine map, so each input has exactly one image.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

`ifdef SBOX_FWD_EN
  logic mode_q, mode_d;

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = gf_inv(x);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rdy_en_q <= 1'b0;
`ifdef SBOX_FWD_EN
      mode_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rdy_en_q <= rdy_en_d;
`ifdef SBOX_FWD_EN
      mode_q   <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rdy_en_d = 1'b1;
`ifdef SBOX_FWD_EN
    mode_d   = mode_q;
`endif
    accept   = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SUB;
          cnt_d   = '0;
          data_d  = in_block;
`ifdef SBOX_FWD_EN
          mode_d  = in_inv;
`endif
        end
      end
      SUB: begin
        for (int c = 0; c < N; c++) begin
          if (cnt_q == CNT_W'(c)) begin
            for (int l = 0; l < LANES; l++) begin
`ifdef SBOX_FWD_EN
              data_d[(c*LANES+l)*8 +: 8] = mode_q ? inv_sbox(data_q[(c*LANES+l)*8 +: 8])
                                                  : fwd_sbox(data_q[(c*LANES+l)*8 +: 8]);
`else
              data_d[(c*LANES+l)*8 +: 8] = inv_sbox(data_q[(c*LANES+l)*8 +: 8]);
`endif
            end
          end
        end
        if (cnt_q == CNT_W'(N-1)) state_d = DONE;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        // A block offered during the handshake cycle starts immediately (no bubble).
        if (out_ready) begin
          if (accept) begin
            state_d = SUB;
            cnt_d   = '0;
            data_d  = in_block;
`ifdef SBOX_FWD_EN
            mode_d  = in_inv;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready = rdy_en_q;
      SUB:     busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign out_block = data_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine with a queue scoreboard fed at accept time.
`timescale 1ns/1ps
module tb_sub_bytes_engine;
  localparam int BB = 16;
  localparam int LN = 4;
  localparam int W  = 8*BB;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [W-1:0] in_block, out_block;

  sub_bytes_engine #(.BLOCK_BYTES(BB), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] sb[$];
  int           pulse_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [7:0]   fwd_tab[256];
  logic [7:0]   inv_tab[256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Golden tables from the multiplicative-generator walk, inverse by table inversion.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd_tab[p] = x ^ 8'h63;
    end
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] blk, input logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < BB; i++)
      r[8*i +: 8] = inv ? inv_tab[blk[8*i +: 8]] : fwd_tab[blk[8*i +: 8]];
    return r;
  endfunction

  task automatic check_blk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output side: every handshake pops one expected block.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pulse_q.push_back(cyc);
      n_chk++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: got block %h expected no output", out_block);
      end
      if (sb.size() > 0) check_blk("sb_block", out_block, sb.pop_front());
    end
  end

  task automatic send_one(input logic [W-1:0] blk, input logic inv, output int acc);
    logic eff_inv;
    bit   done;
    done = 1'b0;
    acc  = -1;
    in_block = blk;
    in_inv   = inv;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
`ifdef SBOX_FWD_EN
        eff_inv = inv;
`else
        eff_inv = 1'b1;
`endif
        sb.push_back(model(blk, eff_inv));
        acc  = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $error("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
    end
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    n_chk++;
    assert (at >= 0) else begin
      n_fail++;
      $error("FAIL valid_timeout: got out_valid=0 for 100 cycles expected 1");
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check_int(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, at;
    logic [W-1:0] blk, hold;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_inv = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_blk("rst_out_block", out_block, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("rdy_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("rdy_after_edge", in_ready, 1'b1);

    // All 0x63 through the inverse table, with latency.
    send_one({BB{8'h63}}, 1'b1, acc);
    in_valid = 1'b0;
    check_bit("busy_in_sub", busy, 1'b1);
    check_bit("rdy_in_sub", in_ready, 1'b0);
    wait_valid(at);
    check_int("latency", at - acc, 4);
    check_blk("inv_63", out_block, {BB{8'h00}});
    drain("drain_63");

    // Directed inverse values; in_inv flips mid-block and must not matter.
    send_one({4{32'hFF00BDBC}}, 1'b1, acc);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    in_inv = 1'b0;
    wait_valid(at);
    check_blk("inv_directed", out_block, {4{32'h7D52CD78}});
    drain("drain_directed");
    in_inv = 1'b1;

    // Full 256-value inverse sweep, back-to-back.
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < BB; j++) blk[8*j +: 8] = 8'(b*16 + j);
      send_one(blk, 1'b1, acc);
    end
    in_valid = 1'b0;
    drain("drain_sweep");

    // Forward request: honoured only when the forward table is built in.
    send_one({8{16'h5300}}, 1'b0, acc);
    in_valid = 1'b0;
    wait_valid(at);
`ifdef SBOX_FWD_EN
    check_blk("fwd_directed", out_block, {8{16'hED63}});
`else
    check_blk("fwd_disabled", out_block, {8{16'h5052}});
`endif
    drain("drain_fwd");

    // Backpressure: hold DONE for 10 cycles while a junk block is offered.
    out_ready = 1'b0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_one(blk, 1'b1, acc);
    in_valid = 1'b0;
    wait_valid(at);
    hold = out_block;
    check_blk("bp_first", out_block, model(blk, 1'b1));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k < 9);
      in_block = ~blk;
      @(negedge clk);
      check_bit("bp_valid", out_valid, 1'b1);
      check_blk("bp_hold", out_block, hold);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_bit("bp_idle_valid", out_valid, 1'b0);
    check_bit("bp_idle_ready", in_ready, 1'b1);
    check_bit("bp_idle_busy", busy, 1'b0);
    drain("drain_bp");

    // Back-to-back with in_valid held: one result every 5 cycles.
    pulse_q.delete();
    for (int k = 0; k < 4; k++)
      send_one({$urandom, $urandom, $urandom, $urandom}, 1'(k & 1), acc);
    in_valid = 1'b0;
    drain("drain_b2b");
    check_int("b2b_count", pulse_q.size(), 4);
    for (int k = 1; k < pulse_q.size(); k++)
      check_int("b2b_period", pulse_q[k] - pulse_q[k-1], 5);

    // Reset at cnt=2 aborts the block.
    send_one({$urandom, $urandom, $urandom, $urandom}, 1'b1, acc);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_bit("busy_before_rst", busy, 1'b1);
    sb.delete(sb.size() - 1);
    rst = 1'b1;
    #1;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_ready", in_ready, 1'b0);
    check_blk("mid_rst_block", out_block, '0);
    repeat (2) @(posedge clk);
    #1;
    check_bit("mid_rst_ready_held", in_ready, 1'b0);
    rst = 1'b0;
    pulse_q.delete();
    repeat (8) @(posedge clk);
    #1;
    check_int("no_aborted_output", pulse_q.size(), 0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_one(blk, 1'b1, acc);
    in_valid = 1'b0;
    wait_valid(at);
    check_int("post_rst_latency", at - acc, 4);
    drain("drain_post_rst");

    check_int("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
